// File: rtl/filter_dac_tx.sv
// filter_dac_tx: takes one binary16 filter sample per valid/ready handshake,
// converts it to a 12-bit offset-binary DAC code with saturation, and shifts
// {CMD_BITS, code} out as a 16-bit SPI mode-0 frame, MSB first.
// Optional feature macro: FILTER_DAC_SAT_FLAG_EN adds the sticky sat_flag output.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both 1; in_ready is high only while the FSM is in IDLE, and
// in_valid seen at any other time is ignored (no stall, no queueing).
module filter_dac_tx #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [3:0]  CMD_BITS = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    output logic        frame_done
`ifdef FILTER_DAC_SAT_FLAG_EN
    ,
    output logic        sat_flag
`endif
);

    typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, HOLD} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] sample;
    logic [15:0] shreg;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [11:0] conv_code;
    logic [10:0] mag;
    logic        last_div;
    logic [15:0] frame;

    assign in_ready = (state_q == IDLE);
    assign last_div = (div_cnt == DIV_LAST);
    assign frame    = {CMD_BITS, conv_code};

    // Half to offset-binary: |v|*2048 = (1024+man) * 2^(exp-14); below 1.0
    // that is a right shift of the significand, which truncates toward zero.
    always_comb begin
        mag       = '0;
        conv_code = 12'd2048;
        if (sample[14:10] == 5'd31) begin
            // NaN parks at mid-scale; infinities go to the rails
            if (sample[9:0] != 10'd0)
                conv_code = 12'd2048;
            else
                conv_code = sample[15] ? 12'd0 : 12'd4095;
        end else if (sample[14:10] >= 5'd15) begin
            conv_code = sample[15] ? 12'd0 : 12'd4095;
        end else if (sample[14:10] != 5'd0) begin
            mag       = {1'b1, sample[9:0]} >> (5'd14 - sample[14:10]);
            conv_code = sample[15] ? (12'd2048 - {1'b0, mag})
                                   : (12'd2048 + {1'b0, mag});
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: SHIFT ends after the high phase of the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CONVERT;
            CONVERT: state_d = SHIFT;
            SHIFT:   if (last_div && sclk && (bit_cnt == 4'd15)) state_d = HOLD;
            HOLD:    if (last_div) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture, frame load, sclk phase divider and bit shifting.
    // All SPI pins are registered so sclk cannot glitch around cs_n edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample     <= '0;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_cnt <= '0;
                    if (in_valid) sample <= in_data;
                end
                CONVERT: begin
                    mosi    <= frame[15];
                    shreg   <= {frame[14:0], 1'b0};
                    cs_n    <= 1'b0;
                    sclk    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (last_div) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                cs_n       <= 1'b1;
                                frame_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                mosi    <= shreg[15];
                                shreg   <= {shreg[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    div_cnt <= last_div ? 8'd0 : (div_cnt + 8'd1);
                end
                default: div_cnt <= '0;
            endcase
        end
    end

`ifdef FILTER_DAC_SAT_FLAG_EN
    logic conv_sat;

    // Saturated: Inf/NaN, or |v| >= 1.0 except exactly -1.0 (representable)
    always_comb begin
        conv_sat = 1'b0;
        if (sample[14:10] == 5'd31)
            conv_sat = 1'b1;
        else if (sample[14:10] >= 5'd15)
            conv_sat = !(sample[15] && (sample[14:10] == 5'd15) && (sample[9:0] == 10'd0));
    end

    // Sticky flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            sat_flag <= 1'b0;
        else if ((state_q == CONVERT) && conv_sat)
            sat_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_filter_dac_tx.sv
// Bench for filter_dac_tx: two instances (CLK_DIV=2 and CLK_DIV=1) share clk/rst.
// A monitor rebuilds frames from sclk/mosi and compares them with exp queues.
module tb_filter_dac_tx;

  localparam logic [3:0] CMD = 4'b0011;

  logic        clk;
  logic        rst;
  logic [15:0] in_data [2];
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  sclk;
  logic [1:0]  cs_n;
  logic [1:0]  mosi;
  logic [1:0]  frame_done;
`ifdef FILTER_DAC_SAT_FLAG_EN
  logic [1:0]  sat_flag;
`endif

  filter_dac_tx #(.CLK_DIV(2), .CMD_BITS(CMD)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
    .frame_done(frame_done[0])
`ifdef FILTER_DAC_SAT_FLAG_EN
    , .sat_flag(sat_flag[0])
`endif
  );

  filter_dac_tx #(.CLK_DIV(1), .CMD_BITS(CMD)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
    .frame_done(frame_done[1])
`ifdef FILTER_DAC_SAT_FLAG_EN
    , .sat_flag(sat_flag[1])
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [1:0]  sat_exp = 2'b00;

  function automatic int cd_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // Reference conversion from the real value of the half-precision sample
  function automatic void ref_conv(input logic [15:0] h, output logic [11:0] code,
                                   output logic sat);
    int  e;
    int  m;
    int  s;
    real v;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) begin
      sat  = 1'b1;
      code = (m != 0) ? 12'h800 : (h[15] ? 12'h000 : 12'hFFF);
    end else begin
      if (e == 0) v = real'(m) * (2.0 ** (-24.0));
      else        v = real'(1024 + m) * (2.0 ** real'(e - 25));
      if (h[15]) v = -v;
      if (v >= 1.0) begin
        code = 12'hFFF; sat = 1'b1;
      end else if (v < -1.0) begin
        code = 12'h000; sat = 1'b1;
      end else begin
        s    = $rtoi(v * 2048.0);
        code = 12'(s + 2048);
        sat  = 1'b0;
      end
    end
  endfunction

  // ---------------- frame monitor ----------------
  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  aborted = 2'b00;
  logic [15:0] acc [2];
  int nbits [2];
  int low_cnt [2];
  int phase_len [2];
  int gap_cnt [2];
  int last_gap [2];
  int frames_ok [2];
  int aborts [2];
  int done_seen [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      acc[d] = '0; nbits[d] = 0; low_cnt[d] = 0; phase_len[d] = 0; gap_cnt[d] = 0;
      last_gap[d] = 0; frames_ok[d] = 0; aborts[d] = 0; done_seen[d] = 0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (frame_done[d] === 1'b1) done_seen[d]++;
      if (cs_n[d] === 1'b0) begin
        if (prev_cs[d]) begin
          last_gap[d] = gap_cnt[d];
          nbits[d] = 0; low_cnt[d] = 0; phase_len[d] = 0; aborted[d] = 1'b0; acc[d] = '0;
        end
        low_cnt[d]++;
        if (!prev_cs[d] && (sclk[d] != prev_sclk[d])) begin
          check("sclk_phase_len", phase_len[d], cd_of(d));
          phase_len[d] = 1;
        end else begin
          phase_len[d]++;
        end
        if (sclk[d] && !prev_sclk[d]) begin
          acc[d] = {acc[d][14:0], mosi[d]};
          nbits[d]++;
        end
        if (rst) aborted[d] = 1'b1;
      end else if (cs_n[d] === 1'b1) begin
        if (!prev_cs[d]) begin
          gap_cnt[d] = 1;
          if (aborted[d]) begin
            aborts[d]++;
          end else begin
            check("sclk_low_at_cs_rise", sclk[d], 0);
            check("sclk_last_high_len", phase_len[d], cd_of(d));
            check("frame_bits", nbits[d], 16);
            check("cs_low_cycles", low_cnt[d], 32 * cd_of(d));
            if (d == 0 && exp_q0.size() > 0)      check("frame0_data", acc[d], exp_q0.pop_front());
            else if (d == 1 && exp_q1.size() > 0) check("frame1_data", acc[d], exp_q1.pop_front());
            else                                  check("frame_unexpected", 1, 0);
            frames_ok[d]++;
          end
        end else begin
          gap_cnt[d]++;
        end
      end
      prev_cs[d]   = (cs_n[d] === 1'b0) ? 1'b0 : 1'b1;
      prev_sclk[d] = (sclk[d] === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready[d] !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  // One frame from idle, with exact handshake/frame timing checks
  task automatic send_one(input int d, input logic [15:0] data, input logic [11:0] want_code,
                          input logic want_sat);
    int cd;
    int done_k;
    int ready_k;
    int ndone;
    cd = cd_of(d);
    wait_ready(d);
    in_data[d] = data;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data[d] = 16'($urandom);
    push_exp(d, {CMD, want_code});
    sat_exp[d] = sat_exp[d] | want_sat;
    check("ready_low_after_accept", in_ready[d], 0);
    done_k = -1; ready_k = -1; ndone = 0;
    for (int k = 1; k <= 2 + 33 * cd; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        check("cs_low_at_T1", cs_n[d], 0);
        check("mosi_bit15_at_T1", mosi[d], CMD[3]);
      end
      if (frame_done[d] === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (in_ready[d] === 1'b1 && ready_k < 0) ready_k = k;
    end
    check("frame_done_cycle", done_k, 1 + 32 * cd);
    check("frame_done_count", ndone, 1);
    check("ready_return_cycle", ready_k, 1 + 33 * cd);
`ifdef FILTER_DAC_SAT_FLAG_EN
    check("sat_flag", sat_flag[d], sat_exp[d]);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] data;
    logic [11:0] code;
    logic        sat;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [15:0] s3 [3];
    logic [11:0] rc;
    logic        rs;
    logic [15:0] r;
    int d0;
    int a0;
    int f0;
    int n;

    tbl[0]  = '{16'h0000, 12'h800, 1'b0};
    tbl[1]  = '{16'h3800, 12'hC00, 1'b0};
    tbl[2]  = '{16'hB800, 12'h400, 1'b0};
    tbl[3]  = '{16'h1400, 12'h802, 1'b0};
    tbl[4]  = '{16'h0001, 12'h800, 1'b0};
    tbl[5]  = '{16'h8000, 12'h800, 1'b0};
    tbl[6]  = '{16'h0400, 12'h800, 1'b0};
    tbl[7]  = '{16'h3BFF, 12'hFFF, 1'b0};
    tbl[8]  = '{16'hBBFF, 12'h001, 1'b0};
    tbl[9]  = '{16'hBC00, 12'h000, 1'b0};
    tbl[10] = '{16'h3C00, 12'hFFF, 1'b1};
    tbl[11] = '{16'h7C00, 12'hFFF, 1'b1};
    tbl[12] = '{16'hFC00, 12'h000, 1'b1};
    tbl[13] = '{16'h7E00, 12'h800, 1'b1};
    tbl[14] = '{16'hBC01, 12'h000, 1'b1};
    tbl[15] = '{16'h4000, 12'hFFF, 1'b1};
    tbl[16] = '{16'hC000, 12'h000, 1'b1};

    rst = 1'b1;
    in_valid = 2'b00;
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", in_ready[d], 1);
      check("rst_cs_n", cs_n[d], 1);
      check("rst_sclk", sclk[d], 0);
      check("rst_mosi", mosi[d], 0);
      check("rst_frame_done", frame_done[d], 0);
`ifdef FILTER_DAC_SAT_FLAG_EN
      check("rst_sat_flag", sat_flag[d], 0);
`endif
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors on the CLK_DIV=2 instance
    for (int i = 0; i < 17; i++) send_one(0, tbl[i].data, tbl[i].code, tbl[i].sat);

    // Reset in the middle of a frame
    wait_ready(0);
    in_data[0] = 16'h3800;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    d0 = done_seen[0];
    a0 = aborts[0];
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", cs_n[0], 1);
    check("abort_sclk", sclk[0], 0);
    rst = 1'b0;
    sat_exp = 2'b00;
    @(posedge clk); #1;
    check("abort_ready", in_ready[0], 1);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_done", done_seen[0], d0);
    check("abort_seen", aborts[0], a0 + 1);
    send_one(0, 16'h3800, 12'hC00, 1'b0);
    send_one(0, 16'hBC00, 12'h000, 1'b0);

    // Back-to-back with in_valid held high
    s3[0] = 16'h3800; s3[1] = 16'hB800; s3[2] = 16'h1400;
    wait_ready(0);
    f0 = frames_ok[0];
    in_valid[0] = 1'b1;
    in_data[0] = s3[0];
    for (int i = 0; i < 3; i++) begin
      wait_ready(0);
      @(posedge clk); #1;
      ref_conv(s3[i], rc, rs);
      push_exp(0, {CMD, rc});
      sat_exp[0] = sat_exp[0] | rs;
      if (i < 2) in_data[0] = s3[i + 1];
      else       in_valid[0] = 1'b0;
    end
    n = 0;
    while (frames_ok[0] < f0 + 3 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("b2b_frames", frames_ok[0], f0 + 3);
    check("b2b_gap_ge_div", 32'(last_gap[0] >= 2), 1);
    check("b2b_gap_le_div2", 32'(last_gap[0] <= 4), 1);
    check("b2b_queue_empty", exp_q0.size(), 0);

    // CLK_DIV=1 instance: a few table vectors, then randomized
    for (int i = 0; i < 6; i++) send_one(1, tbl[i].data, tbl[i].code, tbl[i].sat);
    for (int i = 0; i < 10; i++) begin
      r = 16'($urandom_range(0, 65535));
      ref_conv(r, rc, rs);
      send_one(1, r, rc, rs);
    end

    // Randomized on CLK_DIV=2, biased toward the interesting exponent range
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) r = 16'($urandom_range(0, 65535));
      else            r = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 16)),
                           10'($urandom_range(0, 1023))};
      ref_conv(r, rc, rs);
      send_one(0, r, rc, rs);
    end

    repeat (10) @(posedge clk);
    #1;
    check("final_queue0_empty", exp_q0.size(), 0);
    check("final_queue1_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
